// File: rtl/mips_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// mips_multicycle_ctrl
//   Moore FSM controller for a multicycle MIPS datapath over one unified
//   memory. It decodes op/funct from the instruction register and drives the
//   datapath mux selects, write enables and ALU control every cycle.
//   Supported: R-type add/sub/and/or/slt, lw, sw, beq, addi, j. Every other
//   opcode/funct is a 2-cycle no-op (FETCH, DECODE) that issues no writes.
//
// Parameters
//   ADDI_EN     1: addi path enabled; 0: opcode 001000 is illegal
//   J_EN        1: j path enabled;    0: opcode 000010 is illegal
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous active-high reset
//   op, funct   IR[31:26] / IR[5:0]
//   zero        ALU zero flag (combinational from the datapath)
//   pcen        PC enable = pcwrite | (branch & zero)
//   memwrite    unified memory write enable
//   irwrite     instruction register load
//   iord        memory address select: 0 = PC, 1 = ALUOut
//   regdst      write register: 0 = rt, 1 = rd
//   memtoreg    write data: 0 = ALUOut, 1 = Data register
//   regwrite    register file write enable
//   alusrca     0 = PC, 1 = A
//   alusrcb     00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
//   pcsrc       00 = ALUResult, 01 = ALUOut, 10 = jump target
//   alucontrol  010 add, 110 sub, 000 and, 001 or, 111 slt
//   state       current state encoding (debug)
// -----------------------------------------------------------------------------
module mips_multicycle_ctrl #(
  parameter bit ADDI_EN = 1'b1,
  parameter bit J_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcen,
  output logic       memwrite,
  output logic       irwrite,
  output logic       iord,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMRD    = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWR    = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BEQ      = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       memwrite;
    logic       irwrite;
    logic       iord;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
  } ctrl_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  state_t state_q, state_d;
  ctrl_t  ctrl_q;

  function automatic logic funct_legal(input logic [5:0] fn);
    return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
           (fn == 6'b100101) || (fn == 6'b101010);
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] fn);
    logic [2:0] alu;
    alu = ALU_ADD;
    case (fn)
      6'b100010: alu = ALU_SUB;
      6'b100100: alu = ALU_AND;
      6'b100101: alu = ALU_OR;
      6'b101010: alu = ALU_SLT;
      default:   alu = ALU_ADD;
    endcase
    return alu;
  endfunction

  // Control word for a given state. Unused encodings decode to all-zero
  // enables, which also covers a state register corrupted into 12..15.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] fn);
    ctrl_t c;
    c            = '0;
    c.alucontrol = ALU_ADD;
    case (s)
      S_FETCH: begin
        c.alusrcb = 2'b01;
        c.irwrite = 1'b1;
        c.pcwrite = 1'b1;
      end
      S_DECODE:   c.alusrcb = 2'b11;
      S_MEMADR: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_MEMRD:    c.iord = 1'b1;
      S_MEMWB: begin
        c.memtoreg = 1'b1;
        c.regwrite = 1'b1;
      end
      S_MEMWR: begin
        c.iord     = 1'b1;
        c.memwrite = 1'b1;
      end
      S_EXECUTE: begin
        c.alusrca    = 1'b1;
        c.alucontrol = funct_alu(fn);
      end
      S_ALUWB: begin
        c.regdst   = 1'b1;
        c.regwrite = 1'b1;
      end
      S_BEQ: begin
        c.alusrca    = 1'b1;
        c.alucontrol = ALU_SUB;
        c.pcsrc      = 2'b01;
        c.branch     = 1'b1;
      end
      S_ADDIEXEC: begin
        c.alusrca = 1'b1;
        c.alusrcb = 2'b10;
      end
      S_ADDIWB:   c.regwrite = 1'b1;
      S_JUMP: begin
        c.pcsrc   = 2'b10;
        c.pcwrite = 1'b1;
      end
      default: begin
        c            = '0;
        c.alucontrol = ALU_ADD;
      end
    endcase
    return c;
  endfunction

  // NOTE: state_d is assigned a default before the case so every path drives
  // it; a missing branch would otherwise infer a latch.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = funct_legal(funct) ? S_EXECUTE : S_FETCH;
          OP_BEQ:       state_d = S_BEQ;
          OP_ADDI:      state_d = ADDI_EN ? S_ADDIEXEC : S_FETCH;
          OP_J:         state_d = J_EN ? S_JUMP : S_FETCH;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (op == OP_LW)      state_d = S_MEMRD;
        else if (op == OP_SW) state_d = S_MEMWR;
        else                  state_d = S_FETCH;
      end
      S_MEMRD:    state_d = S_MEMWB;
      S_EXECUTE:  state_d = S_ALUWB;
      S_ADDIEXEC: state_d = S_ADDIWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // The control word is registered alongside the state, computed from the
  // state being entered, so outputs are glitch-free decodes of the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: reset loads FETCH's control word (irwrite/pcwrite set) so the first
  // cycle after release fetches; the enables are masked while reset is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      ctrl_q  <= decode_ctrl(S_FETCH, 6'd0);
    end else begin
      state_q <= state_d;
      ctrl_q  <= decode_ctrl(state_d, funct);
    end
  end

  // Enables are masked by reset directly so an abort mid-instruction cannot
  // leak a write in the reset cycle. zero is the only data input reaching an
  // output combinationally.
  assign pcen       = ~reset & (ctrl_q.pcwrite | (ctrl_q.branch & zero));
  assign memwrite   = ~reset & ctrl_q.memwrite;
  assign irwrite    = ~reset & ctrl_q.irwrite;
  assign regwrite   = ~reset & ctrl_q.regwrite;
  assign iord       = ctrl_q.iord;
  assign regdst     = ctrl_q.regdst;
  assign memtoreg   = ctrl_q.memtoreg;
  assign alusrca    = ctrl_q.alusrca;
  assign alusrcb    = ctrl_q.alusrcb;
  assign pcsrc      = ctrl_q.pcsrc;
  assign alucontrol = ctrl_q.alucontrol;
  assign state      = state_q;

endmodule
